// File: rtl/data_mem_sized.sv
// Byte-addressable big-endian data memory for the MEM stage with byte/half/word
// accesses, req/done handshake, programmable wait states and error reporting.
module data_mem_sized #(
    parameter int WORD_LEN    = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [WORD_LEN-1:0] address,
    input  logic [WORD_LEN-1:0] dataIn,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [WORD_LEN-1:0] dataOut
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [WORD_LEN:0] DEPTH_EXT = (WORD_LEN+1)'(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [WORD_LEN-1:0] dout_q, dout_d;
    logic [AW-1:0]       a_q, a_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sext_q, sext_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;

    logic [7:0]          mem_q [DEPTH_BYTES];
    logic [AW-1:0]       idx [4];
    logic [7:0]          rbyte [4];
    logic [7:0]          wbyte [4];
    logic [3:0]          wen;
    logic                access;

    // Wide compare so an address near the top of the 32-bit space cannot wrap into range.
    function automatic logic is_illegal(input logic [1:0] sz, input logic [WORD_LEN-1:0] addr);
        logic [WORD_LEN:0] last;
        logic [WORD_LEN:0] off;
        off  = (sz == 2'b10) ? (WORD_LEN+1)'(3) : (sz == 2'b01) ? (WORD_LEN+1)'(1) : '0;
        last = {1'b0, addr} + off;
        return (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
               (sz == 2'b10 && addr[1:0] != 2'b00) || (last >= DEPTH_EXT);
    endfunction

    // w holds the four bytes starting at a, lowest address in the top byte.
    function automatic logic [WORD_LEN-1:0] format_load(input logic [1:0] sz, input logic se,
                                                        input logic [WORD_LEN-1:0] w);
        logic ext;
        ext = se & w[31];
        case (sz)
            2'b00:   return {{24{ext}}, w[31:24]};
            2'b01:   return {{16{ext}}, w[31:16]};
            default: return w;
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k]   = a_q + AW'(k);
            rbyte[k] = mem_q[idx[k]];
        end
    end

    assign access = (state_q == WAIT) && (cnt_q == 4'd0);

    always_comb begin
        for (int k = 0; k < 4; k++) wbyte[k] = wdata_q[31-8*k -: 8];
        wen = 4'b0000;
        case (size_q)
            2'b00: wbyte[0] = wdata_q[7:0];
            2'b01: begin
                wbyte[0] = wdata_q[15:8];
                wbyte[1] = wdata_q[7:0];
            end
            default: ;
        endcase
        if (access && we_q) begin
            case (size_q)
                2'b00:   wen = 4'b0001;
                2'b01:   wen = 4'b0011;
                default: wen = 4'b1111;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        dout_d  = dout_q;
        a_d     = a_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    a_d     = address[AW-1:0];
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sign_ext;
                    wdata_d = dataIn;
                    if (is_illegal(size, address)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT;
                        err_d   = 1'b0;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q)
                        dout_d = format_load(size_q, sext_q,
                                             {rbyte[0], rbyte[1], rbyte[2], rbyte[3]});
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Captured request fields are only meaningful after a capture, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        we_q    <= we_d;
        size_q  <= size_d;
        sext_q  <= sext_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (wen[k]) mem_q[idx[k]] <= wbyte[k];
        end
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        err     = err_q;
        dataOut = dout_q;
    end

endmodule
